// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the playfield game logic (note scheduler, lane
// generators, scoring block).
//   - game_state_e : play-state encoding, also driven out on state_o
//   - NUM_LANES    : number of scrolling note lanes
//   - LANE_W       : width of a lane index
//   - LFSR_POLY    : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   - lfsr_next()  : one right-shifting Galois step
// -----------------------------------------------------------------------------
package game_pkg;

  localparam int          NUM_LANES = 4;
  localparam int          LANE_W    = 2;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAYING   = 2'd2,
    ST_PAUSED    = 2'd3
  } game_state_e;

  // Shift right; when the bit falling out is 1, fold it back through the taps.
  // A nonzero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/note_lfsr.sv
// -----------------------------------------------------------------------------
// note_lfsr
// 16-bit Galois LFSR used for lane selection.
//   clk_i   in  system clock
//   rst_ni  in  synchronous active-low reset (loads the seed)
//   load_i  in  synchronous seed reload (wins over adv_i)
//   adv_i   in  advance one step
//   cand_o  out low LANE_W bits of the current (pre-advance) register
// A zero SEED is replaced by 16'h0001 so the register can never lock up.
// -----------------------------------------------------------------------------
module note_lfsr
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [LANE_W-1:0] cand_o
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)     lfsr_d = SEED_EFF;
    else if (adv_i) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) lfsr_q <= SEED_EFF;
    else         lfsr_q <= lfsr_d;
  end

  assign cand_o = lfsr_q[LANE_W-1:0];

endmodule

// File: rtl/note_scheduler.sv
// -----------------------------------------------------------------------------
// note_scheduler
// Play-state sequencer for the four note lanes: runs IDLE/COUNTDOWN/PLAYING/
// PAUSED, gates lane shift enables and, on a fixed spawn cadence, inserts a
// note into an LFSR-chosen lane that respects a per-lane minimum spacing.
//   clk_i            in  system clock
//   rst_ni           in  synchronous active-low reset
//   step_tick_i      in  one-cycle scroll-step strobe
//   start_i          in  one-cycle pulse, start game
//   pause_i          in  one-cycle pulse, toggle pause
//   stop_i           in  one-cycle pulse, abort to IDLE
//   lane_en_o        out per-lane shift enable (all ones while PLAYING)
//   spawn_o          out one-hot, one-cycle insert-note pulse
//   state_o          out current play state (game_state_e encoding)
//   notes_spawned_o  out spawned-note count, wraps
//   spawn_skips_o    out attempts with no eligible lane, saturates at 255
// Interface semantics: there is no valid/ready handshake. Every input is a
// single-cycle strobe acted on in the cycle it is high (a strobe held high
// acts once per cycle); every output is registered and is valid in the cycle
// after the input that caused it. Same-cycle priority is
// stop > pause > start > tick.
// -----------------------------------------------------------------------------
module note_scheduler
  import game_pkg::*;
#(
  parameter int          NUM_LANES       = 4,
  parameter int          COUNTDOWN_STEPS = 240,
  parameter int          SPAWN_PERIOD    = 36,
  parameter int          MIN_GAP         = 24,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 step_tick_i,
  input  logic                 start_i,
  input  logic                 pause_i,
  input  logic                 stop_i,
  output logic [NUM_LANES-1:0] lane_en_o,
  output logic [NUM_LANES-1:0] spawn_o,
  output logic [1:0]           state_o,
  output logic [15:0]          notes_spawned_o,
  output logic [7:0]           spawn_skips_o
);

  localparam int CD_W  = (COUNTDOWN_STEPS < 2) ? 1 : $clog2(COUNTDOWN_STEPS);
  localparam int SP_W  = (SPAWN_PERIOD < 2)    ? 1 : $clog2(SPAWN_PERIOD);
  localparam int GAP_W = (MIN_GAP < 2)         ? 1 : $clog2(MIN_GAP + 1);

  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COUNTDOWN_STEPS - 1);
  localparam logic [SP_W-1:0]  SP_LOAD  = SP_W'(SPAWN_PERIOD - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

  game_state_e          state_q, state_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic [SP_W-1:0]      tmr_q, tmr_d;
  logic [GAP_W-1:0]     gap_q [NUM_LANES];
  logic [GAP_W-1:0]     gap_d [NUM_LANES];
  logic [15:0]          notes_q, notes_d;
  logic [7:0]           skips_q, skips_d;
  logic [NUM_LANES-1:0] spawn_q, spawn_d;
  logic [NUM_LANES-1:0] lane_en_q, lane_en_d;

  logic              lfsr_load, lfsr_adv;
  logic [LANE_W-1:0] cand;
  logic [LANE_W-1:0] win;
  logic              found;
  logic [LANE_W-1:0] probe;

  note_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (lfsr_load),
    .adv_i  (lfsr_adv),
    .cand_o (cand)
  );

  // Lane selector: probe cand, cand+1, ... (mod 4); first lane whose gap has
  // run out wins. Uses the gaps as they stand before this tick's decrement.
  always_comb begin
    found = 1'b0;
    win   = '0;
    probe = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      probe = cand + LANE_W'(k);
      if (!found && (gap_q[probe] == '0)) begin
        found = 1'b1;
        win   = probe;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    tmr_d     = tmr_q;
    gap_d     = gap_q;
    notes_d   = notes_q;
    skips_d   = skips_q;
    spawn_d   = '0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    // Enable follows the registered state, so it lags state_o by one cycle.
    lane_en_d = (state_q == ST_PLAYING) ? '1 : '0;

    if (stop_i || (state_q == ST_IDLE)) begin
      // Abort, or sitting in IDLE: everything held clear, LFSR back to seed.
      state_d   = ST_IDLE;
      cd_d      = '0;
      tmr_d     = '0;
      for (int i = 0; i < NUM_LANES; i++) gap_d[i] = '0;
      notes_d   = '0;
      skips_d   = '0;
      lfsr_load = 1'b1;
      if (!stop_i && start_i) begin
        state_d = ST_COUNTDOWN;
        cd_d    = CD_LOAD;
      end
    end else begin
      case (state_q)
        ST_COUNTDOWN: begin
          // pause_i has no effect here, so a tick is never dropped.
          if (step_tick_i) begin
            if (cd_q == '0) begin
              state_d = ST_PLAYING;
              tmr_d   = SP_LOAD;
            end else begin
              cd_d = cd_q - CD_W'(1);
            end
          end
        end
        ST_PLAYING: begin
          if (pause_i) begin
            state_d = ST_PAUSED;
          end else if (step_tick_i) begin
            lfsr_adv = 1'b1;
            for (int i = 0; i < NUM_LANES; i++)
              gap_d[i] = (gap_q[i] != '0) ? gap_q[i] - GAP_W'(1) : '0;
            if (tmr_q == '0) begin
              tmr_d = SP_LOAD;
              if (found) begin
                gap_d[win]   = GAP_LOAD;  // load overrides the decrement
                spawn_d[win] = 1'b1;
                notes_d      = notes_q + 16'd1;
              end else if (skips_q != 8'hFF) begin
                skips_d = skips_q + 8'd1;
              end
            end else begin
              tmr_d = tmr_q - SP_W'(1);
            end
          end
        end
        ST_PAUSED: begin
          if (pause_i) state_d = ST_PLAYING;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cd_q      <= '0;
      tmr_q     <= '0;
      for (int i = 0; i < NUM_LANES; i++) gap_q[i] <= '0;
      notes_q   <= '0;
      skips_q   <= '0;
      spawn_q   <= '0;
      lane_en_q <= '0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      tmr_q     <= tmr_d;
      for (int i = 0; i < NUM_LANES; i++) gap_q[i] <= gap_d[i];
      notes_q   <= notes_d;
      skips_q   <= skips_d;
      spawn_q   <= spawn_d;
      lane_en_q <= lane_en_d;
    end
  end

  assign state_o         = state_q;
  assign lane_en_o       = lane_en_q;
  assign spawn_o         = spawn_q;
  assign notes_spawned_o = notes_q;
  assign spawn_skips_o   = skips_q;

endmodule

// File: tb/tb_note_scheduler.sv
// -----------------------------------------------------------------------------
// tb_note_scheduler
// Two scheduler instances share clock and reset:
//   u_dut : COUNTDOWN_STEPS=4, SPAWN_PERIOD=2, MIN_GAP=4,  seed 16'h0001
//   u_gap : COUNTDOWN_STEPS=4, SPAWN_PERIOD=1, MIN_GAP=16, seed 16'h0001
// Expected spawn pulses ({cycle, one-hot lane}) are queued when the tick is
// driven; a monitor thread pops and compares whenever spawn_o is nonzero.
// -----------------------------------------------------------------------------
module tb_note_scheduler;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [15:0] pos_cnt = 16'd0;
  always @(posedge clk) pos_cnt <= pos_cnt + 16'd1;

  logic [1:0]  start_v, pause_v, stop_v, tick_v;
  logic [3:0]  lane_en0, spawn0, lane_en1, spawn1;
  logic [1:0]  state0, state1;
  logic [15:0] notes0, notes1;
  logic [7:0]  skips0, skips1;

  note_scheduler #(
    .NUM_LANES(4), .COUNTDOWN_STEPS(4), .SPAWN_PERIOD(2), .MIN_GAP(4),
    .LFSR_SEED(16'h0001)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .step_tick_i(tick_v[0]), .start_i(start_v[0]),
    .pause_i(pause_v[0]), .stop_i(stop_v[0]), .lane_en_o(lane_en0),
    .spawn_o(spawn0), .state_o(state0), .notes_spawned_o(notes0),
    .spawn_skips_o(skips0)
  );

  note_scheduler #(
    .NUM_LANES(4), .COUNTDOWN_STEPS(4), .SPAWN_PERIOD(1), .MIN_GAP(16),
    .LFSR_SEED(16'h0001)
  ) u_gap (
    .clk_i(clk), .rst_ni(rst_n), .step_tick_i(tick_v[1]), .start_i(start_v[1]),
    .pause_i(pause_v[1]), .stop_i(stop_v[1]), .lane_en_o(lane_en1),
    .spawn_o(spawn1), .state_o(state1), .notes_spawned_o(notes1),
    .spawn_skips_o(skips1)
  );

  // scoreboard
  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];
  int checks = 0;
  int errors = 0;

  // Hand-derived lanes for u_dut attempts 1..10 (one-hot): 0,1,2,0,1,2,3,0,1,2
  logic [3:0] lanes_a [10];
  // u_gap attempts 1..8: lanes 1,0,2,3 then four skips
  logic [3:0] lanes_g [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (spawn0 !== 4'h0) begin
        if (exp_q0.size() == 0) chk("spawn0_unexpected", {12'h0, pos_cnt, spawn0}, 32'h0);
        else chk("spawn0_cycle_lane", {12'h0, pos_cnt, spawn0}, {12'h0, exp_q0.pop_front()});
      end
      if (spawn1 !== 4'h0) begin
        if (exp_q1.size() == 0) chk("spawn1_unexpected", {12'h0, pos_cnt, spawn1}, 32'h0);
        else chk("spawn1_cycle_lane", {12'h0, pos_cnt, spawn1}, {12'h0, exp_q1.pop_front()});
      end
    end
  endtask

  // driver: called at a negedge, returns at the next negedge
  task automatic pulse(input int d, input logic st, input logic pa, input logic sp,
                       input logic tk, input logic [3:0] exp_sp);
    if (exp_sp != 4'h0) begin
      if (d == 0) exp_q0.push_back({pos_cnt + 16'd1, exp_sp});
      else        exp_q1.push_back({pos_cnt + 16'd1, exp_sp});
    end
    start_v[d] = st;
    pause_v[d] = pa;
    stop_v[d]  = sp;
    tick_v[d]  = tk;
    @(negedge clk);
    start_v[d] = 1'b0;
    pause_v[d] = 1'b0;
    stop_v[d]  = 1'b0;
    tick_v[d]  = 1'b0;
  endtask

  task automatic tick(input int d, input logic [3:0] exp_sp);
    pulse(d, 1'b0, 1'b0, 1'b0, 1'b1, exp_sp);
  endtask

  initial begin
    logic [3:0] e;
    lanes_a = '{4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
    lanes_g = '{4'h2, 4'h1, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    rst_n   = 1'b0;
    start_v = '0; pause_v = '0; stop_v = '0; tick_v = '0;
    fork
      monitor();
    join_none

    // reset / idle
    repeat (3) @(negedge clk);
    chk("rst_state", state0, 2'd0);
    chk("rst_lane_en", lane_en0, 4'h0);
    chk("rst_spawn", spawn0, 4'h0);
    chk("rst_notes", notes0, 16'd0);
    chk("rst_skips", skips0, 8'd0);
    chk("rst_state_gap", state1, 2'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 4'h0);
      chk("idle_state", state0, 2'd0);
      chk("idle_lane_en", lane_en0, 4'h0);
    end

    // countdown: exactly four ticks
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("cd_enter", state0, 2'd1);
    for (int i = 0; i < 4; i++) begin
      tick(0, 4'h0);
      if (i < 3) chk("cd_hold", state0, 2'd1);
      else begin
        chk("cd_done", state0, 2'd2);
        chk("lane_en_lag", lane_en0, 4'h0);
      end
    end
    @(negedge clk);
    chk("lane_en_play", lane_en0, 4'hF);

    // spawn cadence, with a pause inserted after ten active ticks
    for (int n = 1; n <= 20; n++) begin
      if (n == 11) begin
        chk("notes_before_pause", notes0, 16'd5);
        pulse(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("pause_state", state0, 2'd3);
        @(negedge clk);
        chk("pause_lane_en", lane_en0, 4'h0);
        for (int k = 0; k < 10; k++) begin
          tick(0, 4'h0);
          @(negedge clk);
        end
        chk("pause_notes_frozen", notes0, 16'd5);
        chk("pause_skips", skips0, 8'd0);
        pulse(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("resume_state", state0, 2'd2);
      end
      e = 4'h0;
      if (n % 2 == 0) e = lanes_a[n/2-1];
      tick(0, e);
      @(negedge clk);
    end
    chk("play_notes", notes0, 16'd10);
    chk("play_skips", skips0, 8'd0);

    // stop + pause + tick in one cycle: stop wins
    pulse(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    chk("abort_state", state0, 2'd0);
    chk("abort_notes", notes0, 16'd0);
    chk("abort_skips", skips0, 8'd0);
    @(negedge clk);
    chk("abort_lane_en", lane_en0, 4'h0);

    // restart: pause ignored in countdown, seed and gaps reloaded
    pulse(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    pulse(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("cd_pause_ignored", state0, 2'd1);
    for (int i = 0; i < 4; i++) tick(0, 4'h0);
    chk("restart_play", state0, 2'd2);
    tick(0, 4'h0);
    @(negedge clk);
    tick(0, 4'h1);
    @(negedge clk);
    chk("restart_notes", notes0, 16'd1);

    // gap saturation on u_gap, ticks every cycle
    pulse(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) tick(1, 4'h0);
    chk("gap_play", state1, 2'd2);
    for (int k = 0; k < 8; k++) tick(1, lanes_g[k]);
    @(negedge clk);
    chk("gap_notes", notes1, 16'd4);
    chk("gap_skips", skips1, 8'd4);
    chk("gap_lane_en", lane_en1, 4'hF);

    repeat (3) @(negedge clk);
    chk("sb0_drained", exp_q0.size(), 32'd0);
    chk("sb1_drained", exp_q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
